// File: rtl/maze_map_pkg.sv
// rtl/maze_map_pkg.sv - shared types, limits, colours and wall ROM image for the maze map
package maze_map_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int TILE_W = 5;

  localparam logic [TILE_W-1:0] PF_MIN = 5'd2;
  localparam logic [TILE_W-1:0] PF_MAX = 5'd27;

  localparam logic [9:0] RENDER_OFS = 10'd20;

  localparam logic [2:0] COL_WALL_DEF   = 3'b001;
  localparam logic [2:0] COL_PELLET_DEF = 3'b111;
  localparam logic [2:0] COL_BLANK      = 3'b000;

  // Row index is tile y, bit index is tile x; the border outside PF_MIN..PF_MAX is forced to wall.
  localparam logic [31:0] WALL_ROM [32] = '{
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
    32'h0000_0000, 32'h0000_01F0, 32'h0000_0000, 32'h0000_0000,
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
    32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000,
    32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000,
    32'h0000_8000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000
  };

  function automatic logic is_wall(input logic [TILE_W-1:0] x, input logic [TILE_W-1:0] y);
    if (x < PF_MIN || x > PF_MAX || y < PF_MIN || y > PF_MAX) return 1'b1;
    return WALL_ROM[y][x];
  endfunction

endpackage

// File: rtl/maze_tile_ram.sv
// rtl/maze_tile_ram.sv - 32x32 pellet bitmap, one write port and two asynchronous read ports
module maze_tile_ram (
  input  logic       clk,
  input  logic       i_we,
  input  logic [9:0] i_waddr,
  input  logic       i_wdata,
  input  logic [9:0] i_raddr_a,
  output logic       o_rdata_a,
  input  logic [9:0] i_raddr_b,
  output logic       o_rdata_b
);

  // Contents are deliberately not reset; the init sweep rewrites every cell.
  logic r_mem [1024];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/maze_map.sv
// rtl/maze_map.sv - maze wall lookup, pellet bookkeeping, level FSM and tile renderer
module maze_map
  import maze_map_pkg::*;
#(
  parameter logic [2:0] WALL_COL   = COL_WALL_DEF,
  parameter logic [2:0] PELLET_COL = COL_PELLET_DEF,
  parameter int         SWEEP_LEN  = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic [4:0] qx,
  input  logic [4:0] qy,
  output logic       map_data,
  input  logic [4:0] eat_x,
  input  logic [4:0] eat_y,
  input  logic       eat_valid,
  input  logic       restart,
  input  logic [9:0] shpos,
  input  logic [9:0] svpos,
  output logic [2:0] col,
  output logic [9:0] score,
  output logic       ready,
  output logic       level_done
);

  localparam logic [9:0] SWEEP_LAST = 10'(SWEEP_LEN - 1);

  state_t      r_state;
  logic [9:0]  r_sweep_cnt;
  logic        r_sweep_end;
  logic [10:0] r_pellets_left;
  logic [9:0]  r_score;
  logic        r_map_data;
  logic [2:0]  r_col;
  logic        r_ready;
  logic        r_level_done;

  logic        w_sweep_wall;
  logic        w_eat_pellet;
  logic        w_eat_ok;
  logic        w_we;
  logic [9:0]  w_waddr;
  logic        w_wdata;
  logic [9:0]  w_hsum;
  logic [9:0]  w_vsum;
  logic        w_rend_in;
  logic        w_rend_dot;
  logic        w_rend_pellet;
  logic [2:0]  w_col_next;

  assign w_sweep_wall = is_wall(r_sweep_cnt[4:0], r_sweep_cnt[9:5]);

  assign w_eat_ok = (r_state == ST_PLAY) && ce && eat_valid && w_eat_pellet
                    && !is_wall(eat_x, eat_y) && !restart;

  // Single write port: the sweep owns it in INIT, eats own it in PLAY.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = {eat_y, eat_x};
    w_wdata = 1'b0;
    if (r_state == ST_INIT) begin
      w_we    = !r_sweep_end && !restart;
      w_waddr = r_sweep_cnt;
      w_wdata = !w_sweep_wall;
    end else if (w_eat_ok) begin
      w_we = 1'b1;
    end
  end

  assign w_hsum     = shpos + RENDER_OFS;
  assign w_vsum     = svpos + RENDER_OFS;
  assign w_rend_in  = (w_hsum[9:8] == 2'b00) && (w_vsum[9:8] == 2'b00);
  assign w_rend_dot = (w_hsum[2:0] == 3'd3 || w_hsum[2:0] == 3'd4)
                      && (w_vsum[2:0] == 3'd3 || w_vsum[2:0] == 3'd4);

  maze_tile_ram u_ram (
    .clk       (clk),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a ({eat_y, eat_x}),
    .o_rdata_a (w_eat_pellet),
    .i_raddr_b ({w_vsum[7:3], w_hsum[7:3]}),
    .o_rdata_b (w_rend_pellet)
  );

  always_comb begin
    w_col_next = COL_BLANK;
    if (w_rend_in) begin
      if (is_wall(w_hsum[7:3], w_vsum[7:3])) begin
        w_col_next = WALL_COL;
      end else if (w_rend_pellet && w_rend_dot && r_state != ST_INIT) begin
        w_col_next = PELLET_COL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_INIT;
      r_sweep_cnt    <= '0;
      r_sweep_end    <= 1'b0;
      r_pellets_left <= '0;
      r_score        <= '0;
      r_map_data     <= 1'b0;
      r_col          <= COL_BLANK;
      r_ready        <= 1'b0;
      r_level_done   <= 1'b0;
    end else begin
      r_map_data <= is_wall(qx, qy);
      r_col      <= w_col_next;
      if (restart) begin
        r_state        <= ST_INIT;
        r_sweep_cnt    <= '0;
        r_sweep_end    <= 1'b0;
        r_pellets_left <= '0;
        r_score        <= '0;
        r_ready        <= 1'b0;
        r_level_done   <= 1'b0;
      end else begin
        case (r_state)
          ST_INIT: begin
            if (r_sweep_end) begin
              r_state <= ST_PLAY;
              r_ready <= 1'b1;
            end else begin
              r_sweep_cnt <= r_sweep_cnt + 10'd1;
              if (!w_sweep_wall) r_pellets_left <= r_pellets_left + 11'd1;
              if (r_sweep_cnt == SWEEP_LAST) r_sweep_end <= 1'b1;
            end
          end
          ST_PLAY: begin
            if (w_eat_ok) begin
              if (r_score != 10'h3FF) r_score <= r_score + 10'd1;
              r_pellets_left <= r_pellets_left - 11'd1;
              if (r_pellets_left == 11'd1) begin
                r_state      <= ST_DONE;
                r_ready      <= 1'b0;
                r_level_done <= 1'b1;
              end
            end
          end
          ST_DONE: begin
          end
          default: r_state <= ST_INIT;
        endcase
      end
    end
  end

  assign map_data   = r_map_data;
  assign col        = r_col;
  assign score      = r_score;
  assign ready      = r_ready;
  assign level_done = r_level_done;

endmodule

// File: tb/tb_maze_map.sv
// tb/tb_maze_map.sv - self-checking bench for maze_map with a reference wall/pellet model
module tb_maze_map;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic [4:0] qx = '0;
  logic [4:0] qy = '0;
  logic       map_data;
  logic [4:0] eat_x = '0;
  logic [4:0] eat_y = '0;
  logic       eat_valid = 1'b0;
  logic       restart = 1'b0;
  logic [9:0] shpos = '0;
  logic [9:0] svpos = '0;
  logic [2:0] col;
  logic [9:0] score;
  logic       ready;
  logic       level_done;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    int score;
    int left;
    int done;
  } eat_exp_t;

  int       exp_q[$];
  eat_exp_t eat_q[$];

  bit m_pel [32][32];
  int m_state;
  int m_score;
  int m_left;

  maze_map dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .qx         (qx),
    .qy         (qy),
    .map_data   (map_data),
    .eat_x      (eat_x),
    .eat_y      (eat_y),
    .eat_valid  (eat_valid),
    .restart    (restart),
    .shpos      (shpos),
    .svpos      (svpos),
    .col        (col),
    .score      (score),
    .ready      (ready),
    .level_done (level_done)
  );

  always #5 clk = ~clk;

  function automatic bit model_wall(input int x, input int y);
    if (x < 2 || x > 27 || y < 2 || y > 27) return 1'b1;
    if (y == 5 && x >= 4 && x <= 8) return 1'b1;
    if (x == 15 && y >= 12 && y <= 20) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_col(input int h, input int v);
    int hs, vs, tx, ty, px, py;
    hs = (h + 20) % 1024;
    vs = (v + 20) % 1024;
    tx = hs / 8;  ty = vs / 8;
    px = hs % 8;  py = vs % 8;
    if (tx > 31 || ty > 31) return 0;
    if (model_wall(tx, ty)) return 1;
    if (m_state != 0 && m_pel[tx][ty] && px >= 3 && px <= 4 && py >= 3 && py <= 4) return 7;
    return 0;
  endfunction

  function automatic void model_init();
    m_state = 1;
    m_score = 0;
    m_left  = 0;
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++) begin
        m_pel[x][y] = !model_wall(x, y);
        if (m_pel[x][y]) m_left++;
      end
  endfunction

  function automatic void model_eat(input int x, input int y, input bit c);
    if (m_state == 1 && c && m_pel[x][y] && !model_wall(x, y)) begin
      m_pel[x][y] = 1'b0;
      if (m_score < 1023) m_score++;
      m_left--;
      if (m_left == 0) m_state = 2;
    end
  endfunction

  // Counts edges until ready rises; also probes the INIT pellet mask on the way.
  task automatic wait_ready(input string nm);
    int k;
    k = 0;
    m_state = 0;
    while (!ready && k < 1200) begin
      @(negedge clk);
      k++;
      if (k == 601) begin
        n_run++;
        if (col !== 3'(exp_q.pop_front())) begin
          n_fail++;
          $display("FAIL %s_init_mask: col=%0d expected 0", nm, col);
        end
      end
      if (k == 600) begin
        shpos = 10'd63; svpos = 10'd63;
        exp_q.push_back(model_col(63, 63));
      end
    end
    n_run++;
    if (k !== 1025) begin
      n_fail++;
      $display("FAIL %s_ready_latency: got %0d cycles expected 1025", nm, k);
    end
    model_init();
    n_run++;
    if (score !== 10'd0) begin
      n_fail++;
      $display("FAIL %s_score: got %0d expected 0", nm, score);
    end
    n_run++;
    if (dut.r_pellets_left !== 11'(m_left)) begin
      n_fail++;
      $display("FAIL %s_pellets_left: got %0d expected %0d", nm, dut.r_pellets_left, m_left);
    end
    n_run++;
    if (level_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_level_done: got %0d expected 0", nm, level_done);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_run++;
    if ({ready, level_done, map_data, col, score} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got r=%0d d=%0d m=%0d c=%0d s=%0d expected all 0",
               ready, level_done, map_data, col, score);
    end
    rst_n = 1'b1;
    wait_ready("reset");
  endtask

  task automatic test_map_query();
    int xs[7] = '{1, 10, 5, 15, 27, 28, 0};
    int ys[7] = '{5, 10, 5, 12, 27, 10, 31};
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_run++;
        if (map_data !== 1'(exp_q.pop_front())) begin
          n_fail++;
          $display("FAIL map_query_%0d: map_data=%0d expected %0d", i - 1, map_data, ~map_data);
        end
      end
      if (i < 7) begin
        qx = 5'(xs[i]); qy = 5'(ys[i]);
        exp_q.push_back(model_wall(xs[i], ys[i]));
      end
    end
  endtask

  task automatic test_render(input string nm);
    int hs[8] = '{60, 63, 64, 65, 0, 1000, 1010, 12};
    int vs[8] = '{60, 63, 64, 63, 0, 60, 60, 23};
    int e;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = exp_q.pop_front();
        n_run++;
        if (col !== 3'(e)) begin
          n_fail++;
          $display("FAIL %s_%0d: col=%0d expected %0d", nm, i - 1, col, e);
        end
      end
      if (i < 8) begin
        shpos = 10'(hs[i]); svpos = 10'(vs[i]);
        exp_q.push_back(model_col(hs[i], vs[i]));
      end
    end
  endtask

  task automatic test_eat_repeat();
    int ex[7] = '{10, 10, 10, 11, 5, 1, 10};
    int ey[7] = '{10, 10, 10, 10, 5, 1, 10};
    bit ec[7] = '{1, 1, 1, 0, 1, 1, 1};
    eat_exp_t e;
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = eat_q.pop_front();
        n_run++;
        if (score !== 10'(e.score) || dut.r_pellets_left !== 11'(e.left)) begin
          n_fail++;
          $display("FAIL eat_repeat_%0d: score=%0d left=%0d expected %0d/%0d",
                   i - 1, score, dut.r_pellets_left, e.score, e.left);
        end
      end
      if (i < 7) begin
        eat_x = 5'(ex[i]); eat_y = 5'(ey[i]); ce = ec[i]; eat_valid = 1'b1;
        model_eat(ex[i], ey[i], ec[i]);
        eat_q.push_back('{m_score, m_left, 0});
      end else begin
        eat_valid = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    eat_exp_t e;
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = eat_q.pop_front();
        n_run++;
        if (score !== 10'(e.score) || dut.r_pellets_left !== 11'(e.left)) begin
          n_fail++;
          $display("FAIL back_to_back_%0d: score=%0d left=%0d expected %0d/%0d",
                   i - 1, score, dut.r_pellets_left, e.score, e.left);
        end
      end
      if (i < 3) begin
        eat_x = 5'(11 + i); eat_y = 5'd10; ce = 1'b1; eat_valid = 1'b1;
        model_eat(11 + i, 10, 1'b1);
        eat_q.push_back('{m_score, m_left, 0});
      end else begin
        eat_valid = 1'b0;
      end
    end
  endtask

  task automatic test_eat_all();
    eat_exp_t e;
    ce = 1'b1;
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++)
        if (m_pel[x][y]) begin
          eat_x = 5'(x); eat_y = 5'(y); eat_valid = 1'b1;
          model_eat(x, y, 1'b1);
          eat_q.push_back('{m_score, m_left, (m_state == 2) ? 1 : 0});
          @(negedge clk);
          e = eat_q.pop_front();
          n_run++;
          if (score !== 10'(e.score) || dut.r_pellets_left !== 11'(e.left)
              || level_done !== 1'(e.done)) begin
            n_fail++;
            $display("FAIL eat_all_%0d_%0d: score=%0d left=%0d done=%0d expected %0d/%0d/%0d",
                     x, y, score, dut.r_pellets_left, level_done, e.score, e.left, e.done);
          end
        end
    eat_x = 5'd10; eat_y = 5'd10;
    model_eat(10, 10, 1'b1);
    exp_q.push_back(m_score);
    @(negedge clk);
    eat_valid = 1'b0;
    n_run++;
    if (score !== 10'(exp_q.pop_front()) || level_done !== 1'b1 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL done_frozen: score=%0d done=%0d ready=%0d expected %0d/1/0",
               score, level_done, ready, m_score);
    end
  endtask

  task automatic test_restart();
    restart = 1'b1; eat_valid = 1'b1; ce = 1'b1; eat_x = 5'd2; eat_y = 5'd2;
    @(negedge clk);
    restart = 1'b0; eat_valid = 1'b0;
    n_run++;
    if (ready !== 1'b0 || score !== 10'd0 || level_done !== 1'b0 || dut.r_sweep_cnt !== 10'd0) begin
      n_fail++;
      $display("FAIL restart_state: ready=%0d score=%0d done=%0d cnt=%0d expected 0/0/0/0",
               ready, score, level_done, dut.r_sweep_cnt);
    end
    wait_ready("restart");
  endtask

  task automatic test_async_reset();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    qx = 5'd0; qy = 5'd0; shpos = 10'd1010; svpos = 10'd1010;
    repeat (500) @(negedge clk);
    n_run++;
    if (dut.r_sweep_cnt !== 10'd500 || map_data !== 1'b1 || col !== 3'd1) begin
      n_fail++;
      $display("FAIL pre_async: cnt=%0d map=%0d col=%0d expected 500/1/1",
               dut.r_sweep_cnt, map_data, col);
    end
    #2 rst_n = 1'b0;
    #1;
    n_run++;
    if ({ready, level_done, map_data, col, score} !== 15'd0 || dut.r_sweep_cnt !== 10'd0) begin
      n_fail++;
      $display("FAIL async_reset: r=%0d d=%0d m=%0d c=%0d s=%0d cnt=%0d expected all 0",
               ready, level_done, map_data, col, score, dut.r_sweep_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("async");
  endtask

  initial begin
    m_state = 0;
    test_reset();
    test_map_query();
    test_render("render_full");
    test_eat_repeat();
    test_render("render_eaten");
    test_back_to_back();
    test_eat_all();
    test_restart();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
